// File: rtl/mul_share_arbiter_if.sv
// Requester and multiplier side signals of the shared multiplier arbiter.
// slave = arbiter view, master = requesters plus multiplier view.
interface mul_share_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data1;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data2;
  logic [NUM_REQ-1:0]           ack;
  logic [DATA_SIZE-1:0]         result;
  logic                         result_ovf;
  logic                         result_err;
  logic                         mul_start;
  logic [DATA_SIZE-1:0]         mul_data1;
  logic [DATA_SIZE-1:0]         mul_data2;
  logic                         mul_done;
  logic [DATA_SIZE-1:0]         mul_out;
  logic                         mul_ovf;
  logic                         busy;
  logic                         clr_status;
  logic                         ovf_sticky;

  modport slave (
    input  req, req_data1, req_data2,
    input  mul_done, mul_out, mul_ovf,
    input  clr_status,
    output ack, result, result_ovf, result_err,
    output mul_start, mul_data1, mul_data2,
    output busy, ovf_sticky
  );

  modport master (
    output req, req_data1, req_data2,
    output mul_done, mul_out, mul_ovf,
    output clr_status,
    input  ack, result, result_ovf, result_err,
    input  mul_start, mul_data1, mul_data2,
    input  busy, ovf_sticky
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one multi-cycle multiplier between requesters,
// with a done-timeout watchdog and sticky overflow status.
module mul_share_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  mul_share_arbiter_if.slave bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t               state;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        grant;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic [NUM_REQ-1:0]   ack_q;
  logic [DATA_SIZE-1:0] result_q;
  logic                 ovf_q;
  logic                 err_q;
  logic                 start_q;
  logic [DATA_SIZE-1:0] d1_q;
  logic [DATA_SIZE-1:0] d2_q;
  logic                 busy_q;
  logic                 sticky_q;

  logic [GW-1:0]        pick;
  logic                 found;
  int                   rr_idx;

  // First set request scanning upward from the one after last_grant.
  always_comb begin
    pick   = last_grant;
    found  = 1'b0;
    rr_idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && bus.req[rr_idx]) begin
        pick  = GW'(rr_idx);
        found = 1'b1;
      end
    end
  end

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      cnt        <= '0;
      ack_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      busy_q     <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      if (bus.clr_status)
        sticky_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant   <= pick;
            d1_q    <= bus.req_data1[pick*DATA_SIZE +: DATA_SIZE];
            d2_q    <= bus.req_data2[pick*DATA_SIZE +: DATA_SIZE];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (bus.mul_done) begin
            result_q <= bus.mul_out;
            ovf_q    <= bus.mul_ovf;
            err_q    <= 1'b0;
            ack_q    <= ONE << grant;
            state    <= RESP;
          end else if (TIMEOUT != 0 && cnt_inc == TO) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b1;
            ack_q    <= ONE << grant;
            state    <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant;
          // A set here overrides a same-cycle clear above.
          if (ovf_q || err_q)
            sticky_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.result     = result_q;
  assign bus.result_ovf = ovf_q;
  assign bus.result_err = err_q;
  assign bus.mul_start  = start_q;
  assign bus.mul_data1  = d1_q;
  assign bus.mul_data2  = d2_q;
  assign bus.busy       = busy_q;
  assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: vector table plus
// hand sequences for round-robin, operand hold, clear race and reset.
module tb_mul_share_arbiter;

  localparam int DS  = 8;
  localparam int NR  = 4;
  localparam int TMO = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.DATA_SIZE(DS), .NUM_REQ(NR)) bus();

  mul_share_arbiter #(
    .DATA_SIZE(DS),
    .NUM_REQ  (NR),
    .TIMEOUT  (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Multiplier model: done L cycles after the start cycle.
  int              lat = 1;
  bit              hang = 1'b0;
  logic            extra_done = 1'b0;
  logic            m_done;
  logic [DS-1:0]   m_out;
  logic            m_ovf;
  int              rem;
  logic [2*DS-1:0] prod;

  assign prod = {{DS{1'b0}}, bus.mul_data1}
              * {{DS{1'b0}}, bus.mul_data2};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0;
      m_out  <= '0;
      m_ovf  <= 1'b0;
      rem    <= 0;
    end else begin
      m_done <= 1'b0;
      if (bus.mul_start && !hang) begin
        m_out <= prod[DS-1:0];
        m_ovf <= |prod[2*DS-1:DS];
        if (lat == 1) m_done <= 1'b1;
        rem <= lat - 1;
      end else if (rem > 0) begin
        if (rem == 1) m_done <= 1'b1;
        rem <= rem - 1;
      end
    end
  end

  assign bus.mul_done = m_done | extra_done;
  assign bus.mul_out  = m_out;
  assign bus.mul_ovf  = m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*DS-1:0] d1;
    logic [NR*DS-1:0] d2;
    int               lat;
    bit               hang;
    bit               clr;
    logic [NR-1:0]    e_ack;
    logic [DS-1:0]    e_res;
    bit               e_ovf;
    bit               e_err;
    bit               e_sticky;
    int               e_cyc;
  } vec_t;

  vec_t vt[7];

  function automatic vec_t mk(
    logic [NR-1:0] r, logic [NR*DS-1:0] a, logic [NR*DS-1:0] b,
    int l, bit h, bit c, logic [NR-1:0] ea, logic [DS-1:0] er,
    bit eo, bit ee, bit es, int ec);
    vec_t v;
    v.req = r; v.d1 = a; v.d2 = b;
    v.lat = l; v.hang = h; v.clr = c;
    v.e_ack = ea; v.e_res = er;
    v.e_ovf = eo; v.e_err = ee;
    v.e_sticky = es; v.e_cyc = ec;
    return v;
  endfunction

  task automatic wait_ack(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) got = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.clr_status = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int cyc, starts, scyc, gi;
    bit got, busy_ok;
    logic [DS-1:0] sd1, sd2;
    string p;
    p = $sformatf("v%0d", n);
    bus.req = v.req;
    bus.req_data1 = v.d1;
    bus.req_data2 = v.d2;
    lat = v.lat;
    hang = v.hang;
    bus.clr_status = v.clr;
    cyc = 0; starts = 0; scyc = -1;
    got = 1'b0; busy_ok = 1'b1;
    sd1 = '0; sd2 = '0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mul_start) begin
        starts++;
        scyc = cyc;
        sd1 = bus.mul_data1;
        sd2 = bus.mul_data2;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.ack != '0) got = 1'b1;
    end
    gi = 0;
    for (int i = 0; i < NR; i++)
      if (v.e_ack[i]) gi = i;
    chk({p, "_ack_seen"}, 32'(got), 1);
    chk({p, "_ack"}, 32'(bus.ack), 32'(v.e_ack));
    chk({p, "_result"}, 32'(bus.result), 32'(v.e_res));
    chk({p, "_ovf"}, 32'(bus.result_ovf), 32'(v.e_ovf));
    chk({p, "_err"}, 32'(bus.result_err), 32'(v.e_err));
    chk({p, "_latency"}, 32'(cyc), 32'(v.e_cyc));
    chk({p, "_start_cyc"}, 32'(scyc), 1);
    chk({p, "_starts"}, 32'(starts), 1);
    chk({p, "_busy"}, 32'(busy_ok), 1);
    chk({p, "_mul_d1"}, 32'(sd1), 32'(v.d1[gi*DS +: DS]));
    chk({p, "_mul_d2"}, 32'(sd2), 32'(v.d2[gi*DS +: DS]));
    bus.req = bus.req & ~bus.ack;
    @(negedge clk);
    chk({p, "_ack_pulse"}, 32'(bus.ack), 0);
    chk({p, "_idle"}, 32'(bus.busy), 0);
    chk({p, "_sticky"}, 32'(bus.ovf_sticky), 32'(v.e_sticky));
    bus.clr_status = 1'b0;
  endtask

  initial begin
    bit got;
    int cyc;
    int acks;
    logic [NR-1:0] ea;

    bus.req = '0;
    bus.req_data1 = '0;
    bus.req_data2 = '0;
    bus.clr_status = 1'b0;

    vt[0] = mk(4'b0001, 32'h00_00_00_03, 32'h00_00_00_07,
               4, 0, 0, 4'b0001, 8'd21, 0, 0, 0, 6);
    vt[1] = mk(4'b0100, 32'h00_64_00_00, 32'h00_64_00_00,
               2, 0, 0, 4'b0100, 8'd16, 1, 0, 1, 4);
    vt[2] = mk(4'b0010, 32'h00_00_0c_00, 32'h00_00_0a_00,
               1, 0, 1, 4'b0010, 8'd120, 0, 0, 0, 3);
    vt[3] = mk(4'b1000, 32'h04_00_00_00, 32'h04_00_00_00,
               1, 1, 0, 4'b1000, 8'd0, 0, 1, 1, 12);
    vt[4] = mk(4'b0001, 32'h00_00_00_05, 32'h00_00_00_06,
               3, 0, 1, 4'b0001, 8'd30, 0, 0, 0, 5);
    vt[5] = mk(4'b0110, 32'h00_07_02_00, 32'h00_09_03_00,
               2, 0, 0, 4'b0010, 8'd6, 0, 0, 0, 4);
    vt[6] = mk(4'b0100, 32'h00_07_02_00, 32'h00_09_03_00,
               5, 0, 0, 4'b0100, 8'd63, 0, 0, 0, 7);

    do_reset();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_start", 32'(bus.mul_start), 0);
    chk("rst_sticky", 32'(bus.ovf_sticky), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_mul_d1", 32'(bus.mul_data1), 0);

    for (int i = 0; i < 7; i++)
      run_vec(i, vt[i]);

    chk("hold_mul_d1", 32'(bus.mul_data1), 32'd7);

    // Operand change one cycle after the grant edge is ignored.
    hang = 1'b0;
    lat = 3;
    bus.req_data1 = 32'h00_00_00_05;
    bus.req_data2 = 32'h00_00_00_02;
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req_data1 = 32'h00_00_00_09;
    wait_ack(got, cyc);
    chk("stab_ack", 32'(bus.ack), 32'h1);
    chk("stab_result", 32'(bus.result), 32'd10);
    bus.req = '0;
    @(negedge clk);

    // Clear in the same cycle as an overflow response.
    lat = 2;
    bus.req_data1 = 32'h00_00_00_64;
    bus.req_data2 = 32'h00_00_00_64;
    bus.req = 4'b0001;
    wait_ack(got, cyc);
    chk("race_ovf", 32'(bus.result_ovf), 1);
    bus.req = '0;
    bus.clr_status = 1'b1;
    @(negedge clk);
    bus.clr_status = 1'b0;
    chk("race_sticky", 32'(bus.ovf_sticky), 1);
    bus.clr_status = 1'b1;
    @(negedge clk);
    bus.clr_status = 1'b0;
    chk("clr_sticky", 32'(bus.ovf_sticky), 0);

    // Round-robin with all requesters held.
    do_reset();
    lat = 1;
    bus.req_data1 = 32'h04_03_02_01;
    bus.req_data2 = 32'h02_02_02_02;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(got, cyc);
      ea = 4'b0001 << (k % NR);
      chk($sformatf("rr%0d_ack", k), 32'(bus.ack), 32'(ea));
      chk($sformatf("rr%0d_res", k), 32'(bus.result),
          32'(2 * (k % NR + 1)));
    end
    bus.req = '0;
    @(negedge clk);

    // Reset in WAIT, then a stray done after release.
    hang = 1'b1;
    bus.req_data1 = 32'h00_00_00_05;
    bus.req_data2 = 32'h00_00_00_05;
    bus.req = 4'b0010;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_zero",
        32'({bus.ack, bus.result, bus.result_ovf,
             bus.result_err, bus.mul_start, bus.busy,
             bus.ovf_sticky}), 0);
    chk("mid_rst_data",
        32'({bus.mul_data1, bus.mul_data2}), 0);
    bus.req = '0;
    hang = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.ack != '0) acks++;
    end
    chk("late_done_acks", 32'(acks), 0);
    chk("late_done_busy", 32'(bus.busy), 0);
    bus.req = 4'b1111;
    wait_ack(got, cyc);
    chk("post_rst_grant", 32'(bus.ack), 32'h1);
    chk("post_rst_lat", 32'(cyc), 3);
    bus.req = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one multi-cycle multiplier stage (booth multiplier wrapper: start/done handshake, DATA_SIZE operands, overflow flag) between NUM_REQ requesters in the Euler datapath, e.g. parallel h*f(x) products per state variable.
- Grants requesters round-robin and latches operands.
- Sequences start/done on the multiplier and returns the result with a one-cycle ack to the granted requester.
- Adds a done-timeout watchdog and a sticky overflow status.

Parameters:
- DATA_SIZE, 32, operand/result width in bits.
- NUM_REQ, 4, number of requesters, 2..8.
- TIMEOUT, 255, maximum cycles spent in WAIT before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all registers rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NUM_REQ  request per requester; held high until its ack.
- req_data1  in  NUM_REQ*DATA_SIZE  operand 1; requester i at bits [i*DATA_SIZE +: DATA_SIZE].
- req_data2  in  NUM_REQ*DATA_SIZE  operand 2; same packing as req_data1.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- result  out  DATA_SIZE  product; valid only while ack is nonzero.
- result_ovf  out  1  overflow for this result; valid with ack.
- result_err  out  1  timeout abort; valid with ack.
- mul_start  out  1  start pulse to the multiplier.
- mul_data1  out  DATA_SIZE  latched operand 1.
- mul_data2  out  DATA_SIZE  latched operand 2.
- mul_done  in  1  multiplier completion.
- mul_out  in  DATA_SIZE  multiplier product.
- mul_ovf  in  1  multiplier overflow flag.
- busy  out  1  high in every state except IDLE.
- clr_status  in  1  synchronous clear of ovf_sticky.
- ovf_sticky  out  1  set by any accepted overflow or timeout.

Behaviour:
- Reset (async, rst=1): state=IDLE; last_grant=NUM_REQ-1; all of the following are 0: ack, result, result_ovf, result_err, mul_start, mul_data1, mul_data2, ovf_sticky, busy, and the wait counter.
- Reset mid-operation is an abort: no ack is issued, and any in-flight mul_done is ignored after reset.
- FSM, one transition per clock:
  - IDLE: if req != 0, pick the first set bit scanning last_grant+1, +2, … (mod NUM_REQ). Latch its operands into mul_data1/2, store grant index, go to ISSUE. Otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle; clear wait counter; go to WAIT.
  - WAIT: mul_start=0; counter increments each cycle.
    - mul_done=1: capture mul_out into result and mul_ovf into result_ovf; result_err=0; go to RESP.
    - Else, TIMEOUT!=0 and counter==TIMEOUT: result=0, result_ovf=0, result_err=1; go to RESP.
    - mul_done takes priority if both occur in the same cycle.
  - RESP: ack[grant]=1 for this cycle only; last_grant=grant; go to IDLE.
- Requester rules:
  - A requester must see its ack before dropping req.
  - Operands are sampled only at the grant edge; later changes are ignored.
  - Dropping req after grant does not abort; the ack is still issued.
  - The earliest re-grant is the cycle after RESP; back-to-back service costs one IDLE cycle.
- Latency: with req high in IDLE at cycle 0 and multiplier latency L (mul_done high L cycles after the mul_start cycle):
  - mul_start is high in cycle 1;
  - ack is high in cycle 2+L;
  - minimum latency is 3 cycles, at L=1.
- Round-robin: last_grant updates only in RESP. A single persistent requester is re-granted every time. No requester waits more than NUM_REQ-1 other services.
- ovf_sticky:
  - Set in RESP if result_ovf or result_err is 1.
  - clr_status=1 clears it; a set in the same cycle wins over clear.
- mul_done outside WAIT is ignored.
- mul_data1/2 hold their value after RESP until the next grant.
- Widths:
  - Operands and result pass through unchanged; there is no arithmetic in this block.
  - The grant index is clog2(NUM_REQ) bits.
  - The wait counter is wide enough for TIMEOUT.

Test Plan:
1. Single request: req=0001, data1=3, data2=7, multiplier model L=4 → mul_start in cycle 1, mul_data1=3, mul_data2=7; ack=0001 in cycle 6 with result=21, result_ovf=0, result_err=0; busy high cycles 1-6.
2. Round-robin fairness: req=1111 held continuously, each ack followed by an immediate re-request → grant order 0,1,2,3,0; exactly one ack bit per RESP.
3. Overflow and sticky: DATA_SIZE=8, operands 100*100, model flags overflow → result_ovf=1 with ack; ovf_sticky=1 afterwards. Then clr_status pulse with no overflow → ovf_sticky=0. clr_status in the same cycle as an overflow RESP → ovf_sticky stays 1.
4. Timeout: TIMEOUT=10, model never raises mul_done → ack in cycle 12 with result_err=1 and result=0; ovf_sticky=1; the next request is serviced normally.
5. Operand stability: change req_data1 from 5 to 9 one cycle after grant, data2=2 → result=10.
6. Reset mid-WAIT: assert rst, then a late mul_done pulse → no ack; all outputs 0 immediately on rst; after release, state=IDLE and the first grant goes to requester 0.
